// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the multi-channel divider.
// Imported by clk_div_chan and clk_div_multi.
package clk_div_pkg;

  localparam int unsigned DIV_OFF  = 0;
  localparam int unsigned DIV_THRU = 1;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one programmable divider channel with shadow divisor.
// Ports: clk_i, rst_i (sync, high), sync_i restart, we_i/div_i config write,
//        pend_o shadow busy, clk_o level, tick_o period strobe, active_o.
// Optional CLKDIV_ODD50_EN: negedge flag gives 50% duty for odd divisors.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned DIV_INIT = 12000000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sync_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o,
  output logic             active_o
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_INIT);
  localparam logic [WIDTH-1:0] OFF     = WIDTH'(DIV_OFF);
  localparam logic [WIDTH-1:0] THRU    = WIDTH'(DIV_THRU);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] shd_q, shd_d;
  logic [WIDTH-1:0] half_d;
  logic             pend_q, pend_d;
  logic             run_q, run_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             act;

  assign act = (div_q != OFF);

  // run_q marks a live period; it is clear in the first cycle after
  // reset so that cycle shows cnt=0 with outputs still low.
  always_comb begin
    cnt_d  = cnt_q + WIDTH'(1);
    div_d  = div_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    run_d  = run_q;
    if (!act) begin
      if (we_i) div_d = div_i;
      cnt_d = '0;
      run_d = (div_d != OFF);
    end else begin
      if (sync_i || !run_q || (cnt_q == div_q - THRU)) begin
        if (pend_q) begin
          div_d  = shd_q;
          pend_d = 1'b0;
        end
        cnt_d = '0;
        run_d = (div_d != OFF);
      end
      if (we_i) begin
        shd_d  = div_i;
        pend_d = 1'b1;
      end
    end
    half_d = (div_d >> 1) + WIDTH'(div_d[0]);
    clk_d  = run_d && (cnt_d < half_d);
    tick_d = run_d && (cnt_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      div_q  <= DIV_RST;
      shd_q  <= '0;
      pend_q <= 1'b0;
      run_q  <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      run_q  <= run_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

`ifdef CLKDIV_ODD50_EN
  logic neg_q;

  // Half-cycle delayed copy trims the first half of the high phase.
  always_ff @(negedge clk_i) begin
    if (rst_i) neg_q <= 1'b0;
    else       neg_q <= clk_q;
  end

  assign clk_o = (div_q[0] && (div_q > THRU)) ? (clk_q & neg_q) : clk_q;
`else
  assign clk_o = clk_q;
`endif

  assign pend_o   = pend_q;
  assign tick_o   = tick_q;
  assign active_o = act;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH programmable clock dividers with runtime config.
// Ports: clk_i, rst_i (sync, high), sync_i, cfg_valid_i/cfg_ready_o,
//        cfg_ch_i, cfg_div_i, cfg_err_o, clk_out_o, tick_o, active_o.
// Optional CLKDIV_ODD50_EN: 50% duty for odd divisors (see clk_div_chan).
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int unsigned NUM_CH   = 4,
  parameter  int unsigned WIDTH    = 24,
  parameter  int unsigned DIV_INIT = 12000000,
  localparam int unsigned CH_W     = ch_w(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sync_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [WIDTH-1:0]  cfg_div_i,
  output logic              cfg_err_o,
  output logic [NUM_CH-1:0] clk_out_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] active_o
);

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] we;
  logic [NUM_CH-1:0] pend;
  logic              oor;
  logic              acc;
  logic              err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign hit[i] = (cfg_ch_i == CH_W'(i));
    assign we[i]  = acc & hit[i];

    clk_div_chan #(
      .WIDTH    (WIDTH),
      .DIV_INIT (DIV_INIT)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .sync_i   (sync_i),
      .we_i     (we[i]),
      .div_i    (cfg_div_i),
      .pend_o   (pend[i]),
      .clk_o    (clk_out_o[i]),
      .tick_o   (tick_o[i]),
      .active_o (active_o[i])
    );
  end

  // No channel matched: request is swallowed and flagged.
  assign oor         = ~|hit;
  assign cfg_ready_o = oor | ~|(hit & pend);
  assign acc         = cfg_valid_i & cfg_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= acc & oor;
  end

  assign cfg_err_o = err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scoreboard bench for clk_div_multi (3 channels).
// Expected outputs are queued at stimulus time and popped per cycle.
module tb_clk_div_multi;

  localparam int NCH = 3;
  localparam int W   = 8;
  localparam int DI  = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sync = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic [W-1:0]   cfg_div = '0;
  logic           cfg_err;
  logic [NCH-1:0] clk_out, tick, active;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NUM_CH   (NCH),
    .WIDTH    (W),
    .DIV_INIT (DI)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sync_i      (sync),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_ch_i    (cfg_ch),
    .cfg_div_i   (cfg_div),
    .cfg_err_o   (cfg_err),
    .clk_out_o   (clk_out),
    .tick_o      (tick),
    .active_o    (active)
  );

  // Reference state: divisor, shadow, phase within period, started flag.
  int         m_div[NCH];
  int         m_shd[NCH];
  int         m_ph[NCH];
  bit         m_pend[NCH];
  bit         m_live[NCH];
  bit         m_err;
  logic [9:0] exp_q[$];
  logic [9:0] e, got;

  task automatic model_step();
    logic [9:0] v;
    bit take;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_div[c] = DI; m_shd[c] = 0; m_ph[c] = 0;
        m_pend[c] = 0; m_live[c] = 0;
      end
      m_err = 0;
    end else begin
      m_err = cfg_valid && (int'(cfg_ch) >= NCH);
      for (int c = 0; c < NCH; c++) begin
        take = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
        if (m_div[c] == 0) begin
          if (take) m_div[c] = int'(cfg_div);
          m_ph[c] = 0;
          m_live[c] = (m_div[c] != 0);
        end else begin
          if (sync || !m_live[c] || (m_ph[c] + 1 == m_div[c])) begin
            if (m_pend[c]) begin
              m_div[c] = m_shd[c];
              m_pend[c] = 0;
            end
            m_ph[c] = 0;
            m_live[c] = (m_div[c] != 0);
          end else begin
            m_ph[c]++;
          end
          if (take) begin
            m_shd[c] = int'(cfg_div);
            m_pend[c] = 1;
          end
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      v[c]     = m_live[c] && (2 * m_ph[c] < m_div[c]);
      v[3 + c] = m_live[c] && (m_ph[c] == 0);
      v[6 + c] = (m_div[c] != 0);
    end
    v[9] = m_err;
    exp_q.push_back(v);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
      if (got !== e) begin n_fail++; $display("FAIL reset_hold got=%b exp=%b", got, e); end
    end
    n_run++;
    if ({cfg_err, tick, clk_out} !== '0 || active !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_state got=%b/%b/%b exp=0/0/111", clk_out, tick, active);
    end
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      cycle();
      e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
      if (got !== e) begin n_fail++; $display("FAIL reset_run got=%b exp=%b", got, e); end
      n_run++;
      if (clk_out !== {NCH{(k % 6) < 3}} || tick !== {NCH{(k % 6) == 0}}) begin
        n_fail++;
        $display("FAIL reset_pattern k=%0d got=%b/%b", k, clk_out, tick);
      end
    end
  endtask

  task automatic test_odd();
    int first;
    logic [19:0] ck, tk;
    bit bad;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
    cycle();
    cfg_valid = 1'b0;
    e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
    if (got !== e) begin n_fail++; $display("FAIL odd_cfg got=%b exp=%b", got, e); end
    first = -1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
      if (got !== e) begin n_fail++; $display("FAIL odd_run got=%b exp=%b", got, e); end
      ck[k] = clk_out[0];
      tk[k] = tick[0];
      if (tk[k] && first < 0) first = k;
    end
    bad = (first < 0) || (first > 9);
    if (!bad)
      for (int j = 0; j < 10; j++)
        if (ck[first + j] !== ((j % 5) < 3)) bad = 1;
    n_run++;
    if (bad) begin n_fail++; $display("FAIL odd_duty first=%0d got=%b exp 3-high/2-low", first, ck); end
  endtask

  task automatic test_pending();
    int k;
    k = 0;
    while (m_ph[1] != 2 && k < 12) begin
      cycle();
      e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
      if (got !== e) begin n_fail++; $display("FAIL pend_wait got=%b exp=%b", got, e); end
      k++;
    end
    n_run++;
    if (m_ph[1] != 2) begin n_fail++; $display("FAIL pend_timeout ph=%0d exp=2", m_ph[1]); end
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd4;
    n_run++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL pend_ready_pre got=%b exp=1", cfg_ready); end
    cycle();
    cfg_valid = 1'b0;
    e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
    if (got !== e) begin n_fail++; $display("FAIL pend_cfg got=%b exp=%b", got, e); end
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin
        cycle();
        e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
        if (got !== e) begin n_fail++; $display("FAIL pend_hold got=%b exp=%b", got, e); end
      end
      n_run++;
      if (cfg_ready !== (j == 3)) begin
        n_fail++;
        $display("FAIL pend_ready j=%0d got=%b exp=%b", j, cfg_ready, j == 3);
      end
    end
    for (int j = 0; j < 8; j++) begin
      if (j > 0) begin
        cycle();
        e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
        if (got !== e) begin n_fail++; $display("FAIL pend_new got=%b exp=%b", got, e); end
      end
      n_run++;
      if (clk_out[1] !== ((j % 4) < 2)) begin
        n_fail++;
        $display("FAIL pend_d4 j=%0d got=%b exp=%b", j, clk_out[1], (j % 4) < 2);
      end
    end
  endtask

  task automatic test_idle();
    int k;
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
    cycle();
    cfg_valid = 1'b0;
    e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
    if (got !== e) begin n_fail++; $display("FAIL idle_cfg got=%b exp=%b", got, e); end
    k = 0;
    while (m_div[2] != 0 && k < 10) begin
      cycle();
      e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
      if (got !== e) begin n_fail++; $display("FAIL idle_wait got=%b exp=%b", got, e); end
      k++;
    end
    n_run++;
    if (active[2] !== 1'b0 || clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_off got=%b%b%b exp=000", active[2], clk_out[2], tick[2]);
    end
    cfg_valid = 1'b1; cfg_div = 8'd1;
    cycle();
    cfg_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) cycle();
      e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
      if (got !== e) begin n_fail++; $display("FAIL idle_thru got=%b exp=%b", got, e); end
      n_run++;
      if ({clk_out[2], tick[2]} !== 2'b11) begin
        n_fail++;
        $display("FAIL idle_thru_lvl got=%b%b exp=11", clk_out[2], tick[2]);
      end
    end
  endtask

  task automatic test_sync();
    sync = 1'b1;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd6;
    cycle();
    sync = 1'b0; cfg_valid = 1'b0;
    e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
    if (got !== e) begin n_fail++; $display("FAIL sync_edge got=%b exp=%b", got, e); end
    n_run++;
    if (tick !== 3'b111 || clk_out !== 3'b111) begin
      n_fail++;
      $display("FAIL sync_align got=%b/%b exp=111/111", tick, clk_out);
    end
    n_run++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL sync_pend got=%b exp=0", cfg_ready); end
    for (int k = 0; k < 12; k++) begin
      cycle();
      e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
      if (got !== e) begin n_fail++; $display("FAIL sync_run got=%b exp=%b", got, e); end
    end
  endtask

  task automatic test_err_rst();
    logic [NCH-1:0] pre;
    pre = active;
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd9;
    n_run++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready got=%b exp=1", cfg_ready); end
    cycle();
    cfg_valid = 1'b0;
    e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
    if (got !== e) begin n_fail++; $display("FAIL err_edge got=%b exp=%b", got, e); end
    n_run++;
    if (cfg_err !== 1'b1 || active !== pre) begin
      n_fail++;
      $display("FAIL err_pulse got=%b/%b exp=1/%b", cfg_err, active, pre);
    end
    cycle();
    e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
    if (got !== e) begin n_fail++; $display("FAIL err_after got=%b exp=%b", got, e); end
    n_run++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%b exp=0", cfg_err); end
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
    cycle();
    cfg_valid = 1'b0;
    e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
    if (got !== e) begin n_fail++; $display("FAIL rst_pendcfg got=%b exp=%b", got, e); end
    rst = 1'b1;
    cycle();
    e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
    if (got !== e) begin n_fail++; $display("FAIL rst_mid got=%b exp=%b", got, e); end
    n_run++;
    if (clk_out !== '0 || tick !== '0 || active !== 3'b111) begin
      n_fail++;
      $display("FAIL rst_mid_state got=%b/%b/%b exp=000/000/111", clk_out, tick, active);
    end
    rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      cycle();
      e = exp_q.pop_front(); got = {cfg_err, active, tick, clk_out}; n_run++;
      if (got !== e) begin n_fail++; $display("FAIL rst_resume got=%b exp=%b", got, e); end
      n_run++;
      if (clk_out !== {NCH{(k % 6) < 3}} || tick !== {NCH{(k % 6) == 0}}) begin
        n_fail++;
        $display("FAIL rst_pattern k=%0d got=%b/%b", k, clk_out, tick);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_odd();
    test_pending();
    test_idle();
    test_sync();
    test_err_rst();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
